// File: rtl/ex_stage.sv
// Execute stage of a Y86-style pipeline: ALU, condition codes, branch/cmov condition,
// EX/MEM pipeline register with stall/bubble control and a RUN/HALTED machine.
module ex_stage #(
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ex_icode,
  input  logic [3:0]  ex_ifun,
  input  logic [31:0] ex_valA,
  input  logic [31:0] ex_valB,
  input  logic [31:0] ex_valC,
  input  logic [3:0]  ex_dstE,
  input  logic [3:0]  ex_dstM,
  input  logic        set_cc_en,
  input  logic        stall,
  input  logic        bubble,
  output logic [3:0]  mem_icode,
  output logic        mem_cnd,
  output logic [31:0] mem_valE,
  output logic [31:0] mem_valA,
  output logic [3:0]  mem_dstE,
  output logic [3:0]  mem_dstM,
  output logic [2:0]  mem_stat,
  output logic [2:0]  cc_o,
  output logic        halted
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic {S_RUN, S_HALTED} state_t;

  typedef struct packed {
    logic [3:0]  icode;
    logic        cnd;
    logic [31:0] val_e;
    logic [31:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [2:0]  stat;
  } ex_mem_t;

  localparam ex_mem_t NOP = '{icode: 4'h1, cnd: 1'b0, val_e: 32'h0, val_a: 32'h0,
                              dst_e: RNONE, dst_m: RNONE, stat: STAT_AOK};

  ex_mem_t    ex_mem_q, ex_mem_d, computed;
  logic [2:0] cc_q, cc_d;
  state_t     state_q, state_d;

  logic [31:0] val_e;
  logic        cnd;
  logic        zf, sf, of;
  logic        new_of;
  logic [2:0]  stat;

  // cc_q is {ZF,SF,OF}; conditions always look at the pre-update value
  assign zf = cc_q[2];
  assign sf = cc_q[1];
  assign of = cc_q[0];

  always_comb begin
    val_e  = 32'h0;
    new_of = 1'b0;
    case (ex_icode)
      4'h2:       val_e = ex_valA;
      4'h3:       val_e = ex_valC;
      4'h4, 4'h5: val_e = ex_valB + ex_valC;
      4'h6: begin
        case (ex_ifun)
          4'h0: begin
            val_e  = ex_valB + ex_valA;
            new_of = (ex_valA[31] == ex_valB[31]) && (val_e[31] != ex_valA[31]);
          end
          4'h1: begin
            val_e  = ex_valB - ex_valA;
            new_of = (ex_valB[31] != ex_valA[31]) && (val_e[31] != ex_valB[31]);
          end
          4'h2:    val_e = ex_valB & ex_valA;
          4'h3:    val_e = ex_valB ^ ex_valA;
          default: val_e = 32'h0;
        endcase
      end
      4'h8, 4'hA: val_e = ex_valB - 32'd4;
      4'h9, 4'hB: val_e = ex_valB + 32'd4;
      default:    val_e = 32'h0;
    endcase
  end

  always_comb begin
    cnd = 1'b0;
    if (ex_icode == 4'h2 || ex_icode == 4'h7) begin
      case (ex_ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (sf ^ of) | zf;
        4'h2:    cnd = sf ^ of;
        4'h3:    cnd = zf;
        4'h4:    cnd = ~zf;
        4'h5:    cnd = ~(sf ^ of);
        4'h6:    cnd = ~(sf ^ of) & ~zf;
        default: cnd = 1'b0;
      endcase
    end
  end

  always_comb begin
    if (ex_icode == 4'h0)
      stat = STAT_HLT;
    else if (ex_icode > 4'hB || (ex_icode == 4'h6 && ex_ifun > 4'h3))
      stat = STAT_INS;
    else
      stat = STAT_AOK;
  end

  always_comb begin
    computed.icode = ex_icode;
    computed.cnd   = cnd;
    computed.val_e = val_e;
    computed.val_a = ex_valA;
    computed.dst_e = (ex_icode == 4'h2 && !cnd) ? RNONE : ex_dstE;
    computed.dst_m = ex_dstM;
    computed.stat  = stat;
  end

  // HALTED freezes everything; only reset leaves it
  always_comb begin
    ex_mem_d = ex_mem_q;
    cc_d     = cc_q;
    state_d  = state_q;
    if (state_q == S_RUN) begin
      if (!stall) begin
        if (bubble) begin
          ex_mem_d = NOP;
        end else begin
          ex_mem_d = computed;
          if (stat != STAT_AOK) state_d = S_HALTED;
        end
        if (ex_icode == 4'h6 && ex_ifun <= 4'h3 && set_cc_en)
          cc_d = {(val_e == 32'h0), val_e[31], new_of};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_mem_q <= NOP;
      cc_q     <= 3'b100;
      state_q  <= S_RUN;
    end else begin
      ex_mem_q <= ex_mem_d;
      cc_q     <= cc_d;
      state_q  <= state_d;
    end
  end

  assign mem_icode = ex_mem_q.icode;
  assign mem_cnd   = ex_mem_q.cnd;
  assign mem_valE  = ex_mem_q.val_e;
  assign mem_valA  = ex_mem_q.val_a;
  assign mem_dstE  = ex_mem_q.dst_e;
  assign mem_dstM  = ex_mem_q.dst_m;
  assign mem_stat  = ex_mem_q.stat;
  assign cc_o      = cc_q;
  assign halted    = (state_q == S_HALTED);

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: each step drives one instruction, queues the expected
// EX/MEM contents, and checks them one edge later together with CC and halted.
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic [3:0]  ex_icode, ex_ifun, ex_dstE, ex_dstM;
  logic [31:0] ex_valA, ex_valB, ex_valC;
  logic        set_cc_en, stall, bubble;
  logic [3:0]  mem_icode, mem_dstE, mem_dstM;
  logic        mem_cnd;
  logic [31:0] mem_valE, mem_valA;
  logic [2:0]  mem_stat, cc_o;
  logic        halted;

  int total = 0;
  int bad   = 0;

  logic [79:0] exp_q[$];
  logic [79:0] last_exp;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .ex_icode(ex_icode), .ex_ifun(ex_ifun),
    .ex_valA(ex_valA), .ex_valB(ex_valB), .ex_valC(ex_valC),
    .ex_dstE(ex_dstE), .ex_dstM(ex_dstM),
    .set_cc_en(set_cc_en), .stall(stall), .bubble(bubble),
    .mem_icode(mem_icode), .mem_cnd(mem_cnd), .mem_valE(mem_valE), .mem_valA(mem_valA),
    .mem_dstE(mem_dstE), .mem_dstM(mem_dstM), .mem_stat(mem_stat),
    .cc_o(cc_o), .halted(halted)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [79:0] ev(input logic [3:0] icode, input logic cnd,
                                     input logic [31:0] val_e, input logic [31:0] val_a,
                                     input logic [3:0] dst_e, input logic [3:0] dst_m,
                                     input logic [2:0] stat);
    return {icode, cnd, val_e, val_a, dst_e, dst_m, stat};
  endfunction

  function automatic logic [79:0] obs();
    return {mem_icode, mem_cnd, mem_valE, mem_valA, mem_dstE, mem_dstM, mem_stat};
  endfunction

  localparam logic [79:0] RST_VEC = {4'h1, 1'b0, 32'h0, 32'h0, 4'hF, 4'hF, 3'h1};

  task automatic chk(input string tag, input logic [79:0] o, input logic [79:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mem"}, obs(), RST_VEC);
    chk({tag, "_cc"}, 80'(cc_o), 80'(3'b100));
    chk({tag, "_halted"}, 80'(halted), 80'(1'b0));
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; checks land on the following negedge.
  task automatic step(input string tag,
                      input logic [3:0] icode, input logic [3:0] ifun,
                      input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc,
                      input logic [3:0] de, input logic [3:0] dm,
                      input logic en, input logic st, input logic bb,
                      input logic [79:0] exp_mem, input logic [2:0] exp_cc,
                      input logic exp_halt);
    logic [79:0] e;
    ex_icode = icode; ex_ifun = ifun;
    ex_valA = va; ex_valB = vb; ex_valC = vc;
    ex_dstE = de; ex_dstM = dm;
    set_cc_en = en; stall = st; bubble = bb;
    exp_q.push_back(exp_mem);
    last_exp = exp_mem;
    @(posedge clk);
    @(negedge clk);
    // ---------------- scoreboard ----------------
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 80'd1, 80'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_mem"}, obs(), e);
    end
    chk({tag, "_cc"}, 80'(cc_o), 80'(exp_cc));
    chk({tag, "_halted"}, 80'(halted), 80'(exp_halt));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, b, r;
    logic [3:0]  f;
    logic        of;
    logic [2:0]  ecc;

    rst = 1'b0;
    ex_icode = 4'h0; ex_ifun = 4'h0; ex_valA = '0; ex_valB = '0; ex_valC = '0;
    ex_dstE = 4'hF; ex_dstM = 4'hF; set_cc_en = 1'b1; stall = 1'b0; bubble = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;

    step("add_ovf", 4'h6, 4'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 4'h2, 4'hF, 1, 0, 0,
         ev(4'h6, 0, 32'h80000000, 32'h7FFFFFFF, 4'h2, 4'hF, 3'd1), 3'b011, 0);
    step("sub_zero", 4'h6, 4'h1, 32'h5, 32'h5, 32'h0, 4'h3, 4'hF, 1, 0, 0,
         ev(4'h6, 0, 32'h0, 32'h5, 4'h3, 4'hF, 3'd1), 3'b100, 0);
    step("je_taken", 4'h7, 4'h3, 32'h11, 32'h0, 32'h40, 4'hF, 4'hF, 1, 0, 0,
         ev(4'h7, 1, 32'h0, 32'h11, 4'hF, 4'hF, 3'd1), 3'b100, 0);
    step("jne_not", 4'h7, 4'h4, 32'h12, 32'h0, 32'h40, 4'hF, 4'hF, 1, 0, 0,
         ev(4'h7, 0, 32'h0, 32'h12, 4'hF, 4'hF, 3'd1), 3'b100, 0);
    step("add_small", 4'h6, 4'h0, 32'h1, 32'h2, 32'h0, 4'h5, 4'hF, 1, 0, 0,
         ev(4'h6, 0, 32'h3, 32'h1, 4'h5, 4'hF, 3'd1), 3'b000, 0);
    step("cmovl_not", 4'h2, 4'h2, 32'hABCD, 32'h0, 32'h0, 4'h3, 4'hF, 1, 0, 0,
         ev(4'h2, 0, 32'hABCD, 32'hABCD, 4'hF, 4'hF, 3'd1), 3'b000, 0);
    step("rrmovl", 4'h2, 4'h0, 32'h55, 32'h0, 32'h0, 4'h4, 4'hF, 1, 0, 0,
         ev(4'h2, 1, 32'h55, 32'h55, 4'h4, 4'hF, 3'd1), 3'b000, 0);
    step("jg_taken", 4'h7, 4'h6, 32'h21, 32'h0, 32'h0, 4'hF, 4'hF, 1, 0, 0,
         ev(4'h7, 1, 32'h0, 32'h21, 4'hF, 4'hF, 3'd1), 3'b000, 0);
    step("j_bad_ifun", 4'h7, 4'h7, 32'h22, 32'h0, 32'h0, 4'hF, 4'hF, 1, 0, 0,
         ev(4'h7, 0, 32'h0, 32'h22, 4'hF, 4'hF, 3'd1), 3'b000, 0);
    step("irmovl", 4'h3, 4'h0, 32'h0, 32'h0, 32'h1234, 4'h6, 4'hF, 1, 0, 0,
         ev(4'h3, 0, 32'h1234, 32'h0, 4'h6, 4'hF, 3'd1), 3'b000, 0);
    step("mrmovl", 4'h5, 4'h0, 32'h9, 32'h10, 32'h8, 4'hF, 4'h7, 1, 0, 0,
         ev(4'h5, 0, 32'h18, 32'h9, 4'hF, 4'h7, 3'd1), 3'b000, 0);
    step("popl", 4'hB, 4'h0, 32'h0, 32'h100, 32'h0, 4'h4, 4'h4, 1, 0, 0,
         ev(4'hB, 0, 32'h104, 32'h0, 4'h4, 4'h4, 3'd1), 3'b000, 0);
    step("andl", 4'h6, 4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 4'h1, 4'hF, 1, 0, 0,
         ev(4'h6, 0, 32'hF000F000, 32'hF0F0F0F0, 4'h1, 4'hF, 3'd1), 3'b010, 0);
    step("xorl", 4'h6, 4'h3, 32'h1234, 32'h1234, 32'h0, 4'h1, 4'hF, 1, 0, 0,
         ev(4'h6, 0, 32'h0, 32'h1234, 4'h1, 4'hF, 3'd1), 3'b100, 0);

    // Random OPl traffic against an arithmetic reference
    ecc = 3'b100;
    for (int i = 0; i < 8; i++) begin
      f = 4'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i == 0) begin a = 32'h80000000; b = 32'h80000000; f = 4'h0; end
      of = 1'b0;
      case (f)
        4'h0: begin r = b + a; of = (a[31] == b[31]) && (r[31] != a[31]); end
        4'h1: begin r = b - a; of = (a[31] != b[31]) && (r[31] != b[31]); end
        4'h2: r = b & a;
        default: r = b ^ a;
      endcase
      ecc = {(r == 32'h0), r[31], of};
      step("rand_opl", 4'h6, f, a, b, 32'h0, 4'(i), 4'hF, 1, 0, 0,
           ev(4'h6, 0, r, a, 4'(i), 4'hF, 3'd1), ecc, 0);
    end

    step("push_stall_bubble", 4'hA, 4'h0, 32'h7, 32'h100, 32'h0, 4'h4, 4'hF, 1, 1, 1,
         last_exp, ecc, 0);
    step("push_bubble", 4'hA, 4'h0, 32'h7, 32'h100, 32'h0, 4'h4, 4'hF, 1, 0, 1,
         ev(4'h1, 0, 32'h0, 32'h0, 4'hF, 4'hF, 3'd1), ecc, 0);
    step("push_go", 4'hA, 4'h0, 32'h7, 32'h100, 32'h0, 4'h4, 4'hF, 1, 0, 0,
         ev(4'hA, 0, 32'hFC, 32'h7, 4'h4, 4'hF, 3'd1), ecc, 0);
    step("opl_stalled", 4'h6, 4'h0, 32'h1, 32'h1, 32'h0, 4'h2, 4'hF, 1, 1, 0,
         last_exp, ecc, 0);
    step("opl_bubble_cc", 4'h6, 4'h0, 32'h80000000, 32'h80000000, 32'h0, 4'h2, 4'hF, 1, 0, 1,
         ev(4'h1, 0, 32'h0, 32'h0, 4'hF, 4'hF, 3'd1), 3'b101, 0);
    step("opl_cc_off", 4'h6, 4'h0, 32'h1, 32'h1, 32'h0, 4'h2, 4'hF, 0, 0, 0,
         ev(4'h6, 0, 32'h2, 32'h1, 4'h2, 4'hF, 3'd1), 3'b101, 0);
    step("ins_bubbled", 4'h6, 4'h4, 32'h1, 32'h1, 32'h0, 4'h2, 4'hF, 1, 0, 1,
         ev(4'h1, 0, 32'h0, 32'h0, 4'hF, 4'hF, 3'd1), 3'b101, 0);
    step("hlt_stalled", 4'h0, 4'h0, 32'h1, 32'h1, 32'h0, 4'h2, 4'hF, 1, 1, 0,
         last_exp, 3'b101, 0);
    step("bad_icode", 4'hC, 4'h0, 32'h33, 32'h0, 32'h0, 4'h2, 4'hF, 1, 0, 0,
         ev(4'hC, 0, 32'h0, 32'h33, 4'h2, 4'hF, 3'd4), 3'b101, 1);
    step("halted_opl", 4'h6, 4'h0, 32'h1, 32'h1, 32'h0, 4'h2, 4'hF, 1, 0, 0,
         last_exp, 3'b101, 1);
    step("halted_bubble", 4'h3, 4'h0, 32'h0, 32'h0, 32'h9, 4'h2, 4'hF, 1, 0, 1,
         last_exp, 3'b101, 1);

    // Asynchronous reset in the middle of a cycle while halted
    #2 rst = 1'b0;
    #1 check_reset("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_reset("rst_held");
    rst = 1'b1;

    step("halt", 4'h0, 4'h0, 32'h44, 32'h0, 32'h0, 4'h2, 4'hF, 1, 0, 0,
         ev(4'h0, 0, 32'h0, 32'h44, 4'h2, 4'hF, 3'd2), 3'b100, 1);

    rst = 1'b0;
    #1 check_reset("rst2");
    @(negedge clk);
    rst = 1'b1;
    step("opl_bad_ifun", 4'h6, 4'h5, 32'h1, 32'h2, 32'h0, 4'h2, 4'hF, 1, 0, 0,
         ev(4'h6, 0, 32'h0, 32'h1, 4'h2, 4'hF, 3'd4), 3'b100, 1);

    chk("queue_drained", 80'(exp_q.size()), 80'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter: RNONE, 4'hF, register ID meaning "no destination".
REQ-002 SHALL have ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- ex_icode  input  4  instruction code from the ID/EX register.
- ex_ifun  input  4  function code: ALU op or condition.
- ex_valA  input  32  operand A.
- ex_valB  input  32  operand B.
- ex_valC  input  32  constant word.
- ex_dstE  input  4  ALU-result destination register.
- ex_dstM  input  4  memory-result destination register.
- set_cc_en  input  1  permits CC update; 0 when a later stage faults.
- stall  input  1  hold the EX/MEM register.
- bubble  input  1  load a nop into the EX/MEM register.
- mem_icode  output  4  registered icode.
- mem_cnd  output  1  registered condition result.
- mem_valE  output  32  registered ALU result.
- mem_valA  output  32  registered valA pass-through.
- mem_dstE  output  4  registered dstE, after the cmov rule.
- mem_dstM  output  4  registered dstM.
- mem_stat  output  3  registered status: 1 AOK, 2 HLT, 4 INS.
- cc_o  output  3  current {ZF,SF,OF}.
- halted  output  1  1 in HALTED state.

Function
REQ-003 SHALL compute valE combinationally by icode:
- 2 (rrmovl/cmov): valA.
- 3 (irmovl): valC.
- 4/5 (rmmovl/mrmovl): valB+valC.
- 6 (OPl): valB op valA, with ifun 0 add, 1 sub (valB-valA), 2 and, 3 xor.
- 8/A (call/push): valB-4.
- 9/B (ret/pop): valB+4.
- all other codes: 0.
- All arithmetic is modulo 2^32.
REQ-004 SHALL derive new CC for OPl:
- ZF = (result==0); SF = result[31].
- OF for add: a[31]==b[31] && r[31]!=a[31].
- OF for sub: valB[31]!=valA[31] && r[31]!=valB[31].
- OF for and/xor: 0.
REQ-005 SHALL evaluate cnd from the CC value held before this cycle's update:
- ifun 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF.
- ifun 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF.
- Any other ifun gives cnd=0.
- cnd is 0 for icodes other than 2 and 7.
REQ-006 SHALL write CC on a clock edge only when all hold: icode==6, ifun<=3, set_cc_en=1, stall=0, state RUN.
REQ-007 SHALL set the registered dstE to RNONE when icode==2 and cnd==0; otherwise it passes ex_dstE.
REQ-008 SHALL set status: icode 0 gives HLT; icode >4'hB or OPl with ifun>3 gives INS; otherwise AOK.
REQ-009 SHALL update the EX/MEM register each edge by priority:
- stall=1: hold all values.
- else bubble=1: load nop (icode 1, cnd 0, valE 0, valA 0, dstE/dstM RNONE, stat AOK).
- else: load the computed values.
- Simultaneous stall and bubble: stall wins.
REQ-010 SHALL implement state machine RUN/HALTED:
- RUN to HALTED on an edge that loads stat HLT or INS without stall or bubble.
- HALTED exits only by reset.
REQ-011 SHALL, in HALTED, freeze the EX/MEM register and CC regardless of stall, bubble, set_cc_en, or inputs; halted=1.
REQ-012 SHALL give 1-cycle latency from inputs to mem_* outputs; cc_o reflects an update one edge after the qualifying OPl.

Reset
REQ-013 SHALL, on rst low and asynchronously, set:
- mem_icode=1, mem_cnd=0, mem_valE=0, mem_valA=0.
- mem_dstE=mem_dstM=RNONE, mem_stat=1.
- CC={1,0,0}, state RUN, halted=0.
REQ-014 SHALL keep that reset state while rst is low, including reset asserted mid-operation or in HALTED, and SHALL resume on the first edge after release.

Verification
REQ-015 SHALL cover these directed scenarios:
- OPl add with valA=0x7FFFFFFF, valB=1 -> next edge mem_valE=0x80000000, then cc_o={0,1,1}.
- OPl sub with valA=5, valB=5, then jXX ifun 3 -> sub gives valE=0 and CC={1,0,0}; jXX gives mem_cnd=1.
- cmovl (icode 2, ifun 2) with CC={0,0,0>, dstE=3 -> mem_dstE=4'hF, mem_valE=valA.
- pushl with valB=0x100 under stall=1 and bubble=1 -> outputs held; with bubble only -> mem_icode=1; with neither -> mem_valE=0xFC.
- OPl with set_cc_en=0 -> cc_o unchanged; icode 4'hC -> mem_stat=4, halted=1, later inputs ignored.
- rst pulled low in HALTED mid-cycle -> all outputs immediately at REQ-013 values, halted=0.
